// File: rtl/lc3b_types.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lc3b_types : shared LC-3b word/mask types and memory-arbiter states    |
// | Revision   : 1.0                                                       |
// +------------------------------------------------------------------------+
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RECOVER = 2'd3
  } arb_state_t;

  localparam lc3b_mem_wmask c_be_full = 2'b11;

endpackage
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | arb_watchdog : saturating wait counter with sticky timeout flag        |
// | Revision     : 1.0                                                     |
// +------------------------------------------------------------------------+
module arb_watchdog #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic count_i,
  output logic expire_o,
  output logic timeout_err_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign expire_o      = count_i && (cnt_q == CNT_MAX);
  assign timeout_err_o = err_q;

  // Saturates at CNT_MAX so a stuck transaction keeps reporting expiry.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q | expire_o;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | mem_arbiter : shares one physical memory port between I-fetch and D    |
// |               LDR/STR; optional MEM_ARBITER_ROUND_ROBIN_EN fairness    |
// | Revision    : 1.0                                                      |
// +------------------------------------------------------------------------+
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  lc3b_mem_wmask     d_byte_enable,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [DATA_W-1:0] pmem_wdata,
  output lc3b_mem_wmask     pmem_byte_enable,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              grant_d,
  output logic              timeout_err
);

  arb_state_t state_q, state_d;

  logic w_serving;
  logic w_wd_clear;
  logic w_wd_count;
  logic w_wd_expire;
  logic w_d_req;
  logic w_prefer_d;
  logic w_pick_d;

  assign w_serving  = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign w_wd_clear = !w_serving;
  assign w_wd_count = w_serving && !pmem_resp;
  assign w_d_req    = d_read | d_write;
  assign w_pick_d   = w_d_req && (!i_read || w_prefer_d);
  assign grant_d    = (state_q == SERVE_D);

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  // On contention, the port that did not win last time gets the grant.
  assign w_prefer_d = !last_d_q;

  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && state_d == SERVE_D) last_d_d = 1'b1;
    if (state_q == IDLE && state_d == SERVE_I) last_d_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_d_q <= 1'b0;
    else        last_d_q <= last_d_d;
  end
`else
  assign w_prefer_d = 1'b1;
`endif

  arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (w_wd_clear),
    .count_i      (w_wd_count),
    .expire_o     (w_wd_expire),
    .timeout_err_o(timeout_err)
  );

  always_comb begin
    state_d          = state_q;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_addr        = '0;
    pmem_wdata       = '0;
    pmem_byte_enable = c_be_full;
    i_resp           = 1'b0;
    i_rdata          = '0;
    d_resp           = 1'b0;
    d_rdata          = '0;
    case (state_q)
      IDLE: begin
        if (w_pick_d)    state_d = SERVE_D;
        else if (i_read) state_d = SERVE_I;
      end
      SERVE_I: begin
        pmem_read = !w_wd_expire;
        pmem_addr = i_addr;
        i_resp    = pmem_resp | w_wd_expire;
        i_rdata   = pmem_resp ? pmem_rdata : '0;
        if (pmem_resp)        state_d = IDLE;
        else if (w_wd_expire) state_d = RECOVER;
      end
      SERVE_D: begin
        pmem_read        = d_read & !w_wd_expire;
        pmem_write       = d_write & !w_wd_expire;
        pmem_addr        = d_addr;
        pmem_wdata       = d_wdata;
        pmem_byte_enable = d_byte_enable;
        d_resp           = pmem_resp | w_wd_expire;
        d_rdata          = pmem_resp ? pmem_rdata : '0;
        if (pmem_resp)        state_d = IDLE;
        else if (w_wd_expire) state_d = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_mem_arbiter : randomized bench for mem_arbiter against a            |
// |                  transaction-level ownership model                     |
// | Revision       : 1.0                                                   |
// +------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_read;
  logic [15:0] i_addr;
  logic [15:0] i_rdata;
  logic        i_resp;
  logic        d_read;
  logic        d_write;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [1:0]  d_byte_enable;
  logic [15:0] d_rdata;
  logic        d_resp;
  logic        pmem_read;
  logic        pmem_write;
  logic [15:0] pmem_addr;
  logic [15:0] pmem_wdata;
  logic [1:0]  pmem_byte_enable;
  logic [15:0] pmem_rdata;
  logic        pmem_resp;
  logic        grant_d;
  logic        timeout_err;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W (16),
    .DATA_W (16),
    .TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_read          (i_read),
    .i_addr          (i_addr),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_byte_enable   (d_byte_enable),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_addr       (pmem_addr),
    .pmem_wdata      (pmem_wdata),
    .pmem_byte_enable(pmem_byte_enable),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp),
    .grant_d         (grant_d),
    .timeout_err     (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which port owns memory (0 none, 1 I, 2 D), how long it
  // has waited, whether the post-timeout quiet cycle is pending.
  int owner;
  int waited;
  bit recov;
  bit last_d;
  bit m_terr;
  bit e_i_resp;
  bit e_d_resp;

  task automatic model_reset();
    owner    = 0;
    waited   = 0;
    recov    = 1'b0;
    last_d   = 1'b0;
    m_terr   = 1'b0;
    e_i_resp = 1'b0;
    e_d_resp = 1'b0;
  endtask

  task automatic check_and_step();
    bit          expire;
    bit          e_pr, e_pw;
    logic [15:0] e_addr, e_wd, e_ird, e_drd;
    logic [1:0]  e_be;
    int          pick;
    e_pr = 0; e_pw = 0; e_addr = '0; e_wd = '0; e_be = 2'b11;
    e_ird = '0; e_drd = '0; e_i_resp = 0; e_d_resp = 0;
    expire = rst_n && (owner != 0) && !pmem_resp && (waited == TO);
    if (rst_n && owner == 1) begin
      e_pr     = !expire;
      e_addr   = i_addr;
      e_i_resp = pmem_resp || expire;
      e_ird    = pmem_resp ? pmem_rdata : 16'h0;
    end else if (rst_n && owner == 2) begin
      e_pr     = d_read && !expire;
      e_pw     = d_write && !expire;
      e_addr   = d_addr;
      e_wd     = d_wdata;
      e_be     = d_byte_enable;
      e_d_resp = pmem_resp || expire;
      e_drd    = pmem_resp ? pmem_rdata : 16'h0;
    end
    check_eq("strobes", {pmem_read, pmem_write}, {e_pr, e_pw});
    if (!expire) begin
      check_eq("pmem_addr", pmem_addr, e_addr);
      check_eq("pmem_wdata", pmem_wdata, e_wd);
      check_eq("pmem_be", pmem_byte_enable, e_be);
    end
    check_eq("i_resp_rdata", {i_resp, i_rdata}, {e_i_resp, e_ird});
    check_eq("d_resp_rdata", {d_resp, d_rdata}, {e_d_resp, e_drd});
    check_eq("grant_d", grant_d, (rst_n && owner == 2));
    check_eq("timeout_err", timeout_err, m_terr);

    if (!rst_n) begin
      model_reset();
    end else if (recov) begin
      recov = 1'b0;
    end else if (owner != 0) begin
      if (pmem_resp) begin
        owner = 0;
      end else if (expire) begin
        owner  = 0;
        recov  = 1'b1;
        m_terr = 1'b1;
      end else begin
        waited++;
      end
    end else begin
      pick = 0;
      if ((d_read || d_write) && i_read) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        pick = last_d ? 1 : 2;
`else
        pick = 2;
`endif
      end else if (d_read || d_write) begin
        pick = 2;
      end else if (i_read) begin
        pick = 1;
      end
      if (pick != 0) begin
        owner  = pick;
        waited = 0;
        last_d = (pick == 2);
      end
    end
  endtask

  task automatic new_d();
    if ($urandom_range(1) == 1) d_read = 1'b1;
    else                        d_write = 1'b1;
    d_addr        = 16'($urandom);
    d_wdata       = 16'($urandom);
    d_byte_enable = 2'($urandom);
  endtask

  // Requesters hold until their resp, then drop or re-issue immediately.
  task automatic drive_reqs();
    if (i_read) begin
      if (e_i_resp) begin
        if ($urandom_range(1) == 1) i_read = 1'b0;
        else                        i_addr = 16'($urandom);
      end
    end else if ($urandom_range(9) < 4) begin
      i_read = 1'b1;
      i_addr = 16'($urandom);
    end
    if (d_read || d_write) begin
      if (e_d_resp) begin
        d_read  = 1'b0;
        d_write = 1'b0;
        if ($urandom_range(1) == 1) new_d();
      end
    end else if ($urandom_range(9) < 4) begin
      new_d();
    end
  endtask

  task automatic drive_mem(input bit hang);
    pmem_rdata = 16'($urandom);
    if (owner != 0 && !recov) pmem_resp = hang ? 1'b0 : ($urandom_range(2) == 0);
    else                      pmem_resp = ($urandom_range(3) == 0);
  endtask

  task automatic cycle(input bit hang);
    @(posedge clk);
    #1;
    drive_reqs();
    #1;
    drive_mem(hang);
    @(negedge clk);
    check_and_step();
  endtask

  initial begin
    int guard;
    rst_n = 1'b1;
    i_read = 0; i_addr = '0; d_read = 0; d_write = 0; d_addr = '0;
    d_wdata = '0; d_byte_enable = '0; pmem_rdata = '0; pmem_resp = 0;
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    check_eq("reset_outputs",
             {pmem_read, pmem_write, pmem_addr, pmem_byte_enable, i_resp, d_resp, grant_d, timeout_err},
             {1'b0, 1'b0, 16'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_and_step();

    repeat (1500) cycle(1'b0);
    repeat (150) cycle(1'b1);
    check_eq("timeout_seen", m_terr, 1'b1);

    // Asynchronous reset while the I port owns memory.
    guard = 0;
    while (owner != 1 && guard < 500) begin
      cycle(1'b0);
      guard++;
    end
    check_eq("serve_i_reached", owner, 1);
    @(posedge clk);
    #1;
    i_read = 1'b1; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    #1;
    check_eq("pre_reset_pmem_read", pmem_read, (owner == 1 && waited != TO));
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_reset_outputs",
             {pmem_read, pmem_write, pmem_addr, pmem_byte_enable, i_resp, d_resp, grant_d, timeout_err},
             {1'b0, 1'b0, 16'h0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0});
    model_reset();
    repeat (2) begin
      @(posedge clk);
      #2 pmem_resp = 1'b1;
      @(negedge clk);
      check_and_step();
    end
    @(posedge clk);
    #2 rst_n = 1'b1; pmem_resp = 1'b0;
    @(negedge clk);
    check_and_step();
    check_eq("regrant_after_reset", owner, 1);

    repeat (600) cycle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single physical memory port between two requesters: the instruction-fetch port (I) and the data LDR/STR port (D) of the LC-3b multicycle datapath.
- Sits between the control/datapath memory signals and physical memory.
- Grants one requester at a time, holds the grant until the memory responds, then routes the response back to that requester.
- Includes a response-timeout watchdog.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data word width in bits.
- TIMEOUT, 1023, maximum cycles a granted transaction may wait for pmem_resp before it is abandoned.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_read  in  1  I-port read request; held until i_resp.
- i_addr  in  ADDR_W  I-port address.
- i_rdata  out  DATA_W  I-port read data; valid while i_resp=1.
- i_resp  out  1  I-port completion pulse.
- d_read  in  1  D-port read request; held until d_resp.
- d_write  in  1  D-port write request; held until d_resp; never asserted together with d_read.
- d_addr  in  ADDR_W  D-port address.
- d_wdata  in  DATA_W  D-port write data.
- d_byte_enable  in  2  D-port byte mask.
- d_rdata  out  DATA_W  D-port read data; valid while d_resp=1.
- d_resp  out  1  D-port completion pulse.
- pmem_read  out  1  physical read strobe.
- pmem_write  out  1  physical write strobe.
- pmem_addr  out  ADDR_W  physical address.
- pmem_wdata  out  DATA_W  physical write data.
- pmem_byte_enable  out  2  physical byte mask.
- pmem_rdata  in  DATA_W  physical read data.
- pmem_resp  in  1  physical completion.
- grant_d  out  1  1 while the D port owns memory (debug/observe).
- timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-low (rst_n). The reset values below are applied immediately on assertion.
- Reset values: state=IDLE, wait counter=0, timeout_err=0, last-grant=I. All outputs are 0, except pmem_byte_enable=2'b11.
- States: IDLE, SERVE_I, SERVE_D, RECOVER.
- IDLE:
  - No pmem strobes.
  - If d_read|d_write, go to SERVE_D.
  - Else if i_read, go to SERVE_I.
  - Else stay in IDLE.
  - Grant is registered, so a request seen in cycle n drives the pmem strobe from cycle n+1.
- SERVE_x:
  - pmem_* is driven combinationally from port x; pmem_byte_enable=2'b11 for I.
  - The other port's resp stays 0.
  - x_resp = pmem_resp; x_rdata = pmem_rdata in the same cycle.
  - On pmem_resp, go to IDLE. This gives one mandatory idle cycle between transactions, so a held-over request from the finishing port is never regranted.
- Wait counter:
  - Cleared on entry to a SERVE state; increments each SERVE cycle without pmem_resp.
  - At count == TIMEOUT: set timeout_err, emit a one-cycle x_resp with x_rdata=0, drop the pmem strobes, and go to RECOVER.
- RECOVER: one cycle with no strobes, then IDLE. A pmem_resp arriving in IDLE or RECOVER is ignored.
- Unused outputs: i_rdata and d_rdata are 0 whenever their resp is 0.
- Simultaneous requests: D wins under default fixed priority, so the datapath never stalls behind the next fetch.
- Reset mid-transaction: strobes drop immediately and state returns to IDLE. The requester must re-issue.
- Counter width: clog2(TIMEOUT+1). It saturates, never wraps.
- Sticky flag: timeout_err is cleared only by rst_n.

Optional Feature:
- Macro: MEM_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - A last-grant register records the granted port.
  - On simultaneous I and D requests in IDLE, the port not granted last wins.
  - A single pending request is granted regardless of last-grant.
- Undefined: fixed D-over-I priority; the last-grant register is absent.

Decomposition:
- lc3b_types gets:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D, RECOVER}.
  - lc3b_mem_wmask reused for byte masks.
  - lc3b_word reused for 16-bit data/address when ADDR_W = DATA_W = 16.
- Sub-module: arb_watchdog, containing the counter, compare and sticky flag, with inputs clear/count and outputs expire/timeout_err.

Test Plan:
- Lone I read: i_read=1, i_addr=0x0040, pmem_resp after 3 cycles with rdata 0x1234 → pmem_read from cycle 1, pmem_addr=0x0040, i_resp=1 with i_rdata=0x1234 for one cycle, d_resp never asserted.
- Contention: i_read and d_write (addr 0x0100, wdata 0xBEEF, be 2'b01) raised in the same cycle → D served first (pmem_write, be 01), one IDLE cycle, then I served. With MEM_ARBITER_ROUND_ROBIN_EN and last grant D, I is served first.
- Back-to-back D requests held across d_resp → exactly one idle cycle between the two pmem_write pulses; the second pending I is still granted in round-robin mode.
- Timeout with TIMEOUT=8 and pmem_resp held low → d_resp pulse at wait count 8 with d_rdata=0, timeout_err=1 and stays 1, RECOVER for one cycle, then IDLE. A late pmem_resp is ignored.
- Mid-transaction reset: rst_n low during SERVE_I → pmem_read=0 immediately (before the next edge), all outputs at reset values. After release with i_read still high, grant proceeds normally.
